// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged 2-bit counter table with target cache, plus mispredict redirect.
// Optional statistics counters are enabled by defining BRANCH_PRED_STATS_EN.
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    output logic        f_pred_taken,
    output logic [31:0] f_pred_target,
    input  logic        e_valid,
    input  logic        e_is_cf,
    input  logic [31:0] e_pc,
    input  logic        e_taken,
    input  logic [31:0] e_target,
    input  logic        e_pred_taken,
    input  logic [31:0] e_pred_target,
    input  logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic               r_redirect_valid;
    logic [31:0]        r_redirect_pc;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_e_idx;
    logic [TAG_W-1:0] w_e_tag;
    logic             w_e_hit;
    logic             w_update;
    logic             w_mispredict;
    logic [1:0]       w_ctr_cur;
    logic [1:0]       w_ctr_next;

    assign w_f_idx = f_pc[IDX_W+1:2];
    assign w_f_tag = f_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_e_idx = e_pc[IDX_W+1:2];
    assign w_e_tag = e_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads the registered table, so a same-cycle update is seen only from the next cycle.
    assign w_f_hit       = f_valid & r_valid[w_f_idx] & (r_tag[w_f_idx] == w_f_tag);
    assign f_pred_taken  = w_f_hit & r_ctr[w_f_idx][1];
    assign f_pred_target = f_pred_taken ? r_target[w_f_idx] : f_pc + 32'd4;

    assign w_e_hit      = r_valid[w_e_idx] & (r_tag[w_e_idx] == w_e_tag);
    assign w_update     = e_valid & e_is_cf & ~stall;
    assign w_mispredict = w_update &
                          ((e_taken != e_pred_taken) |
                           (e_taken & e_pred_taken & (e_target != e_pred_target)));

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_ctr_cur  = r_ctr[w_e_idx];
        w_ctr_next = w_ctr_cur;
        if (e_taken) begin
            if (w_ctr_cur != 2'd3) w_ctr_next = w_ctr_cur + 2'd1;
        end else begin
            if (w_ctr_cur != 2'd0) w_ctr_next = w_ctr_cur - 2'd1;
        end
    end

    // NOTE: the table is built from flops, not RAM, because reset must clear every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= 2'd0;
                r_target[i] <= 32'd0;
            end
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= e_taken ? e_target : e_pc + 32'd4;
            end
            if (w_update) begin
                if (w_e_hit) begin
                    r_ctr[w_e_idx] <= w_ctr_next;
                    if (e_taken) r_target[w_e_idx] <= e_target;
                end else if (e_taken) begin
                    r_valid[w_e_idx]  <= 1'b1;
                    r_tag[w_e_idx]    <= w_e_tag;
                    r_ctr[w_e_idx]    <= 2'b10;
                    r_target[w_e_idx] <= e_target;
                end
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (w_update)     r_stat_branches    <= r_stat_branches + 32'd1;
            if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
